// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if : execute-stage handshake between the MIPS pipeline and div_unit.
//
//   master (pipeline side) drives : StartE, SignedE, AnnulE, SrcAE, SrcBE
//   slave  (div_unit side) drives : StallDivE, ReadyE, QuotE, RemE
//                                   DivZeroE (only when DIV_ZERO_FLAG_EN is defined)
//
// Build option: DIV_ZERO_FLAG_EN adds the DivZeroE signal.
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             SignedE;
    logic             AnnulE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             StallDivE;
    logic             ReadyE;
    logic [WIDTH-1:0] QuotE;
    logic [WIDTH-1:0] RemE;
`ifdef DIV_ZERO_FLAG_EN
    logic             DivZeroE;
`endif

    modport master (
        output StartE, SignedE, AnnulE, SrcAE, SrcBE,
        input  StallDivE, ReadyE, QuotE, RemE
`ifdef DIV_ZERO_FLAG_EN
        , DivZeroE
`endif
    );

    modport slave (
        input  StartE, SignedE, AnnulE, SrcAE, SrcBE,
        output StallDivE, ReadyE, QuotE, RemE
`ifdef DIV_ZERO_FLAG_EN
        , DivZeroE
`endif
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : iterative radix-2 restoring divider for DIV/DIVU in the E stage.
//
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous active-high reset
//   bus  - div_if.slave : StartE/SignedE/AnnulE/SrcAE/SrcBE in,
//          StallDivE/ReadyE/QuotE(LO)/RemE(HI) out (+DivZeroE, see below)
//
// One shift-subtract step per cycle, WIDTH steps, then a single DONE cycle
// with ReadyE high and the sign-corrected quotient/remainder registered.
// StallDivE holds the front of the pipeline from the start cycle until DONE.
//
// Build option DIV_ZERO_FLAG_EN: a zero divisor short-cuts straight to DONE
// and raises DivZeroE there; otherwise a zero divisor runs the full iteration
// and returns the forced result (quotient all ones, remainder = dividend).
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   quotReg;
    logic [WIDTH-1:0]   divisorReg;
    logic [WIDTH-1:0]   dividendReg;
    logic               quotNeg;
    logic               remNeg;
    logic               zeroDiv;

    logic [WIDTH-1:0]   quotOut;
    logic [WIDTH-1:0]   remOut;

    logic               accept;
    logic               lastStep;
    logic               srcBZero;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               stepGe;
    logic [WIDTH-1:0]   stepRem;
    logic [WIDTH-1:0]   stepQuot;

    // Magnitude of an operand; unsigned operands pass through untouched.
    // The most negative value maps onto itself, which the unsigned datapath
    // reads correctly as 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v,
                                                input logic isSigned);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return (isSigned && (sv < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] fixSign(input logic [WIDTH-1:0] v,
                                                 input logic neg);
        return neg ? -v : v;
    endfunction

    assign srcBZero = (bus.SrcBE == '0);

    // Next state and the combinational shift-subtract step
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        lastStep  = 1'b0;

        // The borrow out of the (WIDTH+1)-bit subtract is the compare result.
        shifted   = {remReg, quotReg[WIDTH-1]};
        diff      = shifted - {1'b0, divisorReg};
        stepGe    = ~diff[WIDTH];
        stepRem   = stepGe ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        stepQuot  = {quotReg[WIDTH-2:0], stepGe};

        unique case (state)
            IDLE: begin
                if (bus.StartE && !bus.AnnulE) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    nextState = srcBZero ? DONE : BUSY;
`else
                    nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                if (bus.AnnulE) begin
                    nextState = IDLE;
                end else if (count == CNT_W'(WIDTH - 1)) begin
                    lastStep  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                // StartE still high here is the same instruction leaving E.
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Control registers and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            quotNeg <= 1'b0;
            remNeg  <= 1'b0;
            zeroDiv <= 1'b0;
            quotOut <= '0;
            remOut  <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                count   <= '0;
                quotNeg <= bus.SignedE & (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
                remNeg  <= bus.SignedE & bus.SrcAE[WIDTH-1];
                zeroDiv <= srcBZero;
`ifdef DIV_ZERO_FLAG_EN
                if (srcBZero) begin
                    quotOut <= '1;
                    remOut  <= bus.SrcAE;
                end
`endif
            end else if (state == BUSY && !bus.AnnulE) begin
                count <= count + 1'b1;
                if (lastStep) begin
                    // A zero divisor bypasses sign correction entirely.
                    quotOut <= zeroDiv ? '1 : fixSign(stepQuot, quotNeg);
                    remOut  <= zeroDiv ? dividendReg : fixSign(stepRem, remNeg);
                end
            end
        end
    end

    // Iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            remReg      <= '0;
            quotReg     <= absVal(bus.SrcAE, bus.SignedE);
            divisorReg  <= absVal(bus.SrcBE, bus.SignedE);
            dividendReg <= bus.SrcAE;
        end else if (state == BUSY) begin
            remReg  <= stepRem;
            quotReg <= stepQuot;
        end
    end

    assign bus.StallDivE = accept | (state == BUSY);
    assign bus.ReadyE    = (state == DONE);
    assign bus.QuotE     = quotOut;
    assign bus.RemE      = remOut;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.DivZeroE  = (state == DONE) & zeroDiv;
`endif

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit : directed self-checking bench for div_unit.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_div_unit;
    localparam int WIDTH = 32;

`ifdef DIV_ZERO_FLAG_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    div_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is the start cycle (cycle 0).
    // StartE stays high until the edge that ends the DONE cycle; with keep=1 it
    // is left high so the next call lands in the following IDLE cycle.
    task automatic doDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] expQ, input logic [31:0] expR,
                         input int expLat, input bit keep);
        int lat;
        int stallCnt;
        lat      = 0;
        stallCnt = 0;
        bus.StartE  = 1'b1;
        bus.SignedE = sgn;
        bus.SrcAE   = a;
        bus.SrcBE   = b;
        @(negedge clk);
        while (!bus.ReadyE && lat < 100) begin
            if (bus.StallDivE) stallCnt++;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                // Operands after the start cycle must not matter.
                bus.SrcAE = ~a;
                bus.SrcBE = b + 32'd3;
            end
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " stallCycles"}, 32'(stallCnt), 32'(expLat));
        check({tag, " stallInDone"}, 32'(bus.StallDivE), 32'd0);
        check({tag, " quot"}, bus.QuotE, expQ);
        check({tag, " rem"}, bus.RemE, expR);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " divZero"}, 32'(bus.DivZeroE), 32'(b == 32'd0));
`endif
        @(posedge clk);
        #1;
        if (!keep) begin
            bus.StartE = 1'b0;
            @(negedge clk);
            check({tag, " readyOneCycle"}, 32'(bus.ReadyE), 32'd0);
            check({tag, " quotHeld"}, bus.QuotE, expQ);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int readyCnt;
        rst         = 1'b1;
        bus.StartE  = 1'b0;
        bus.SignedE = 1'b0;
        bus.AnnulE  = 1'b0;
        bus.SrcAE   = '0;
        bus.SrcBE   = '0;

        // Reset state
        @(negedge clk);
        check("rst ready", 32'(bus.ReadyE), 32'd0);
        check("rst stall", 32'(bus.StallDivE), 32'd0);
        check("rst quot", bus.QuotE, 32'd0);
        check("rst rem", bus.RemE, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst divZero", 32'(bus.DivZeroE), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        doDiv("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);

        // Annul in BUSY, then a fresh division straight after
        bus.StartE  = 1'b1;
        bus.SignedE = 1'b0;
        bus.SrcAE   = 32'd50;
        bus.SrcBE   = 32'd5;
        readyCnt    = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ReadyE) readyCnt++;
            @(posedge clk);
            #1;
        end
        bus.AnnulE = 1'b1;
        bus.StartE = 1'b0;
        @(negedge clk);
        check("annul stallWhileBusy", 32'(bus.StallDivE), 32'd1);
        @(posedge clk);
        #1;
        bus.AnnulE = 1'b0;
        @(negedge clk);
        check("annul noReadyBefore", 32'(readyCnt), 32'd0);
        check("annul ready", 32'(bus.ReadyE), 32'd0);
        check("annul stall", 32'(bus.StallDivE), 32'd0);
        check("annul quotKept", bus.QuotE, 32'd14);
        check("annul remKept", bus.RemE, 32'd2);
        @(posedge clk);
        #1;
        doDiv("divu 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

        // Signed and boundary cases
        doDiv("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        doDiv("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
        doDiv("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0);
        doDiv("divu 1234/0", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, ZERO_LAT, 1'b0);
        doDiv("div -8/0", 32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, ZERO_LAT, 1'b0);
        doDiv("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        doDiv("divu 5/max", 32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 33, 1'b0);

        // StartE held across DONE: second instruction starts the next cycle,
        // so the ReadyE pulses are 34 cycles apart.
        doDiv("divu 20/3", 32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 33, 1'b1);
        doDiv("divu 20/6", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 33, 1'b0);

        // Asynchronous reset in the middle of BUSY
        bus.StartE  = 1'b1;
        bus.SignedE = 1'b0;
        bus.SrcAE   = 32'd1000;
        bus.SrcBE   = 32'd10;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("midrst quotBefore", bus.QuotE, 32'd3);
        rst        = 1'b1;
        bus.StartE = 1'b0;
        #1;
        check("midrst quot", bus.QuotE, 32'd0);
        check("midrst rem", bus.RemE, 32'd0);
        check("midrst ready", 32'(bus.ReadyE), 32'd0);
        check("midrst stall", 32'(bus.StallDivE), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        readyCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ReadyE || bus.StallDivE) readyCnt++;
            @(posedge clk);
            #1;
        end
        check("midrst idleAfter", 32'(readyCnt), 32'd0);
        doDiv("divu 1000/10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 divider in the execute stage of the 5-stage MIPS pipeline; executes DIV/DIVU.
- Raises a stall request to the hazard unit while busy, and accepts an annul (flush) input from it. It is the stall-producing end of the stall/flush interface.
- Quotient goes to LO and remainder to HI; both are registered and valid for one cycle with ReadyE.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- StartE  input  1  execute-stage instruction is DIV/DIVU; held high while the instruction sits in E
- SignedE  input  1  1 = DIV (two's complement), 0 = DIVU
- AnnulE  input  1  cancel the in-flight operation (exception flush)
- SrcAE  input  WIDTH  dividend
- SrcBE  input  WIDTH  divisor
- StallDivE  output  1  stall request to hazard unit (ORed into StallF/StallD/StallE)
- ReadyE  output  1  result valid this cycle
- QuotE  output  WIDTH  quotient (to LO)
- RemE  output  WIDTH  remainder (to HI)
- DivZeroE  output  1  divisor was zero (DIV_ZERO_FLAG_EN only)

Behaviour:
- Reset is asynchronous and active-high. On reset: state IDLE, ReadyE=0, QuotE=0, RemE=0, DivZeroE=0, iteration counter=0.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - If StartE & ~AnnulE: latch |SrcAE|, |SrcBE| (absolute values when SignedE, raw when unsigned), the sign of quotient (A^B), the sign of remainder (A), and the zero-divisor flag. Counter=0. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle performs one restoring shift-subtract step: partial remainder {R,Q} shifted left 1; if R >= divisor, subtract and set the Q LSB.
  - Counter increments. After WIDTH steps (counter==WIDTH-1 on the step cycle), go to DONE.
- DONE:
  - ReadyE=1 for exactly one cycle.
  - QuotE/RemE hold the sign-corrected results: negate Q if quotient sign=1, negate R if remainder sign=1.
  - Next state is IDLE unconditionally.
- Latency: start sampled at cycle N; BUSY spans N+1..N+WIDTH; ReadyE high in cycle N+WIDTH+1.
- StallDivE is combinational:
  - (state==IDLE & StartE & ~AnnulE) | state==BUSY.
  - Low in DONE, so the instruction advances at the end of the DONE cycle.
- StartE still high in DONE belongs to the same instruction and is ignored. StartE high in the following IDLE cycle is a new instruction and is accepted.
- AnnulE in BUSY: return to IDLE next cycle, ReadyE stays 0, QuotE/RemE keep their previous values. AnnulE in DONE: ReadyE still pulses; the pipeline discards it.
- Divisor zero (no macro): full iteration runs with the forced result QuotE=all ones, RemE=SrcAE as latched (original signed value), no sign correction.
- Signed overflow, 0x80000000 / -1: QuotE=0x80000000, RemE=0, the natural wrap of the algorithm.
- Operand changes on SrcAE/SrcBE after the start cycle have no effect.
- Reset mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - DivZeroE port present.
  - Zero divisor in IDLE goes directly to DONE in one cycle, with the same forced result values as the no-macro case; StallDivE is asserted only in the start cycle.
  - DivZeroE=1 during that DONE cycle, 0 otherwise.
- Undefined: port absent; zero divisor takes the full WIDTH+1-cycle latency.

Test Plan:
- DIVU 100/7, start at cycle 0 -> StallDivE high cycles 0..32, ReadyE high cycle 33 only, QuotE=14, RemE=2.
- DIV -7/2 (0xFFFFFFF9 / 0x2) -> QuotE=0xFFFFFFFD (-3), RemE=0xFFFFFFFF (-1); DIV 7/-2 -> QuotE=0xFFFFFFFD, RemE=1.
- DIV 0x80000000 / 0xFFFFFFFF -> QuotE=0x80000000, RemE=0, no hang.
- DIVU 50/5, AnnulE pulsed at BUSY step 10 -> IDLE next cycle, no ReadyE, StallDivE low; then DIVU 9/3 back-to-back -> QuotE=3, RemE=0 after 33 cycles.
- DIVU 1234/0 -> QuotE=0xFFFFFFFF, RemE=1234. Without macro, ReadyE at cycle 33. With DIV_ZERO_FLAG_EN, ReadyE and DivZeroE at cycle 1.
- Two consecutive DIVU (20/3 then 20/6) with StartE held across DONE -> two separate ReadyE pulses 34 cycles apart, results 6 r2 then 3 r2. rst asserted mid-BUSY -> all outputs 0 asynchronously, state IDLE.
